// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-add multiplier: controller state
// encoding, default operand width and the step-counter width helper.
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..w-1; keep at least one bit so w=1 still elaborates.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mult_step.sv
// -----------------------------------------------------------------------------
// mult_step
// One combinational shift-add iteration of the unsigned multiplier.
//   hi, lo   : current partial-product halves (lo also holds the unconsumed
//              multiplier bits)
//   mcand    : multiplicand
//   hi_nxt,
//   lo_nxt   : {carry, hi + (lo[0] ? mcand : 0), lo} >> 1
// -----------------------------------------------------------------------------
module mult_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0] sum;   // bit WIDTH is the carry, shifted back into hi

    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        hi_nxt = sum[WIDTH:1];
        lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end

endmodule

// File: rtl/mult_ctrl.sv
// -----------------------------------------------------------------------------
// mult_ctrl
// Sequential unsigned WIDTH x WIDTH multiplier, one shift-add step per clock.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request; only sampled in IDLE
//   multiplicand,
//   multiplier     : operands, captured on the accepting edge
//   busy           : high while steps are running (RUN)
//   done           : one-cycle pulse, result valid (DONE)
//   product_hi/lo  : live view of the hi/lo registers; hold the result until
//                    the next accepted start
// Latency: accept at E0, steps on E1..E_WIDTH, done for the following cycle.
// -----------------------------------------------------------------------------
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    localparam int              CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] hi, lo, mcand;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    mult_step #(.WIDTH(WIDTH)) u_step (
        .hi     (hi),
        .lo     (lo),
        .mcand  (mcand),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // busy/done are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        hi    <= '0;
                        lo    <= multiplier;
                        mcand <= multiplicand;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    hi    <= hi_nxt;
                    lo    <= lo_nxt;
                    count <= count + CNT_W'(1);
                    if (count == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // start is ignored here; always one IDLE cycle before the next op
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign product_hi = hi;
    assign product_lo = lo;

endmodule

// File: tb/tb_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_ctrl
// Directed bench for mult_ctrl (WIDTH=32). Expected products are pushed to a
// scoreboard queue when an operation is launched and popped on each done.
// -----------------------------------------------------------------------------
module tb_mult_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] multiplicand = '0;
    logic [W-1:0] multiplier = '0;
    logic         busy, done;
    logic [W-1:0] product_hi, product_lo;

    int n_chk  = 0;
    int n_fail = 0;
    logic [2*W-1:0] sb[$];

    mult_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive start for one edge, push the expected product, then scramble the
    // operand inputs so any late sampling shows up in the result.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        @(negedge clk);
        start = 1'b1; multiplicand = a; multiplier = b;
        if (push) sb.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
        @(negedge clk);
        start = 1'b0;
        multiplicand = $urandom; multiplier = $urandom;
    endtask

    // Called at the negedge numbered lat0 after the accepting edge. Walks
    // negedges until done, counting busy cycles, then checks the scoreboard.
    task automatic wait_done(input string tag, input int lat0, input int busy0,
                             output int lat, output int busy_cnt);
        logic [2*W-1:0] exp;
        bit seen = 0;
        lat = lat0; busy_cnt = busy0;
        for (int i = 0; i < 100; i++) begin
            if (busy) busy_cnt++;
            if (done) begin seen = 1; break; end
            @(negedge clk);
            lat++;
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 'x;
            chk({tag, "_prod"}, {product_hi, product_lo}, exp);
        end
    endtask

    initial begin
        int lat, bc, t_prev, n_done, c;

        // Reset state
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", {product_hi, product_lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 3 x 5: latency, busy width, one-cycle done, result hold
        launch(32'd3, 32'd5, 1);
        chk("basic_busy_n1", 64'(busy), 64'd1);
        wait_done("basic", 1, 0, lat, bc);
        chk("basic_lat", 64'(lat), 64'd33);
        chk("basic_busycnt", 64'(bc), 64'd32);
        @(negedge clk);
        chk("basic_done_1cyc", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        chk("basic_hold", {product_hi, product_lo}, 64'h0000_0000_0000_000F);

        // Carry retention
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        wait_done("carry", 1, 0, lat, bc);
        chk("carry_const", {product_hi, product_lo}, 64'hFFFF_FFFE_0000_0001);

        // Zero operand still runs full length
        launch(32'd0, 32'h1234_5678, 1);
        wait_done("zero", 1, 0, lat, bc);
        chk("zero_lat", 64'(lat), 64'd33);

        // Start pulsed while busy is ignored
        launch(32'd7, 32'd9, 1);
        repeat (9) @(negedge clk);
        start = 1'b1; multiplicand = 32'd2; multiplier = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", 11, 10, lat, bc);
        chk("busy_start_lat", 64'(lat), 64'd33);
        chk("busy_start_lo", 64'(product_lo), 64'h3F);
        c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) c++;
        end
        chk("busy_start_no2nd", 64'(c), 64'd0);

        // Reset mid-operation
        launch(32'h0001_0000, 32'h0001_0000, 0);
        repeat (14) @(negedge clk);
        chk("rst_mid_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {product_hi, product_lo, 30'd0, busy, done} == '0 ? 64'd0 : 64'd1, 64'd0);
        c = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) c++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) c++;
        end
        chk("rst_mid_no_done", 64'(c), 64'd0);
        launch(32'd6, 32'd7, 1);
        wait_done("after_rst", 1, 0, lat, bc);
        chk("after_rst_lo", 64'(product_lo), 64'h2A);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1; multiplicand = 32'h8000_0000; multiplier = 32'd2;
        n_done = 0; t_prev = -1; c = 0;
        for (int t = 0; t < 200 && n_done < 3; t++) begin
            @(negedge clk);
            if (busy && !c[0]) sb.push_back(64'h1_0000_0000);
            c = busy ? 1 : 0;
            if (done) begin
                n_done++;
                chk("b2b_prod", {product_hi, product_lo}, sb.size() > 0 ? sb.pop_front() : 'x);
                if (t_prev >= 0) chk("b2b_period", 64'(t - t_prev), 64'd34);
                t_prev = t;
            end
        end
        start = 1'b0;
        chk("b2b_count", 64'(n_done), 64'd3);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all state changes on its rising edge).
REQ-003 rst_n input 1: asynchronous, active-low reset.
REQ-004 start input 1: request a multiply; sampled only in IDLE.
REQ-005 multiplicand input WIDTH: unsigned operand A; captured when start is accepted.
REQ-006 multiplier input WIDTH: unsigned operand B; captured when start is accepted.
REQ-007 busy output 1: high while an operation is running.
REQ-008 done output 1: single-cycle pulse when the result is valid.
REQ-009 product_hi output WIDTH: upper half of the 2*WIDTH result.
REQ-010 product_lo output WIDTH: lower half of the 2*WIDTH result.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE with start=1 at edge E0, the block SHALL load hi=0, lo=multiplier, mcand=multiplicand and count=0, then enter RUN.
REQ-013 On each RUN edge, the block SHALL perform one shift-add step, using lo[0] as the add select:
  - sum = {carry, hi} = hi + (lo[0] ? mcand : 0), computed WIDTH+1 bits wide;
  - {hi, lo} = {carry, hi, lo} >> 1.
REQ-014 The carry-out SHALL be retained, not dropped, so the result is the exact unsigned 2*WIDTH-bit product.
REQ-015 count SHALL increment once per RUN step; after the WIDTH-th step (count==WIDTH-1 at the edge) the FSM SHALL enter DONE.
REQ-016 Steps SHALL occur on edges E1..E32 (WIDTH=32), and done SHALL be high only during the cycle between E32 and E33.
REQ-017 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-018 busy SHALL be 1 in RUN only.
REQ-019 done SHALL be 1 in DONE only, and never for two consecutive cycles.
REQ-020 product_hi and product_lo SHALL reflect hi and lo at all times, and SHALL hold the final result from DONE until the next accepted start.
REQ-021 start while in RUN or DONE SHALL be ignored: no restart, no operand capture.
REQ-022 Operand input changes after acceptance SHALL NOT affect the running operation.
REQ-023 start held high continuously SHALL produce back-to-back operations with one IDLE cycle between them (period WIDTH+2 cycles).
REQ-024 Operand 0 on either side SHALL still take the full WIDTH steps; there is no early termination.

Reset
REQ-025 While rst_n=0, regardless of clk, the block SHALL force state=IDLE, count=0, hi=0, lo=0, mcand=0, busy=0 and done=0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; after reset release, the block SHALL accept a new start normally.

Structure
REQ-027 A shared package mult_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the default width constant.
REQ-028 The count width SHALL be derived from WIDTH in the package or module; the implementation SHALL NOT hard-code it.
REQ-029 One sub-module mult_step SHALL implement the combinational step (WIDTH+1-bit add, select, right shift of {carry, hi, lo}).
REQ-030 The FSM, count and registers SHALL live in mult_ctrl.

Verification
REQ-031 Basic multiply: start with 3 x 5 -> done exactly 33 cycles after the accepting edge; hi=0x00000000, lo=0x0000000F; busy high for 32 cycles.
REQ-032 Carry retention: 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 Zero operand: 0 x 0x12345678 -> hi=0, lo=0; done still takes 33 cycles.
REQ-034 Start while busy: 7 x 9 accepted, then start pulsed with 2 x 2 at cycle 10 -> single done, result lo=0x3F, no second operation.
REQ-035 Reset mid-operation: rst_n low at cycle 15 of a 0x10000 x 0x10000 run -> all outputs 0 immediately, no done; next 6 x 7 -> lo=0x2A.
REQ-036 Back-to-back: start held high with 0x80000000 x 2 -> hi=1, lo=0 on each done, done pulses 34 cycles apart.
